// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-organised data memory for a small core, with a test mailbox that
//   watches stores into a byte-address window and latches a pass/fail
//   verdict.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   reset        asynchronous active-low reset (storage is not cleared)
//   MemWrite     store request, sampled on the rising edge
//   MemWidth     store width: 00 word, 01 half, 10 byte, 11 reserved
//   DataAdr      byte address from the core
//   WriteData    store data, LSB-aligned
//   ReadData     combinational read of the word at DataAdr (0 when out of range)
//   TestDone     mailbox verdict reached
//   TestPass     verdict is pass
//   MisalignErr  sticky flag: an illegal store was dropped
//   WriteCount   saturating count of accepted stores
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] PASS_ADDR   = 32'd100,
    parameter logic [31:0] PASS_VALUE  = 32'd25,
    parameter logic [31:0] IGNORE_ADDR = 32'd96,
    parameter logic [31:0] WIN_LO      = 32'd90,
    parameter logic [31:0] WIN_HI      = 32'd120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [1:0]  MemWidth,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        TestDone,
    output logic        TestPass,
    output logic        MisalignErr,
    output logic [15:0] WriteCount
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        FAIL
    } state_t;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [1:0]    rst_sync;
    logic          active;
    logic [29:0]   word_idx;
    logic [AW-1:0] mem_idx;
    logic          in_range;
    logic          legal;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;
    logic          store_req;
    logic          accept;
    logic          illegal;
    logic          win_hit;
    state_t        state_q;
    state_t        state_d;

    // Release of reset is re-timed through two flops; stores are only
    // honoured once the second flop has seen the release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign active    = rst_sync[1];
    assign word_idx  = DataAdr[31:2];
    assign mem_idx   = word_idx[AW-1:0];
    assign in_range  = ({2'b00, word_idx} < DEPTH_WORDS);
    assign store_req = MemWrite && active;
    assign accept    = store_req && legal && in_range;
    assign illegal   = store_req && !legal;
    assign win_hit   = (DataAdr > WIN_LO) && (DataAdr < WIN_HI);

    // Width decode: replicate the LSB-aligned data across all lanes so the
    // lane enables alone decide which bytes land.
    always_comb begin
        legal     = 1'b0;
        lane_en   = '0;
        lane_data = '0;
        case (MemWidth)
            2'b00: begin
                if (DataAdr[1:0] == 2'b00) begin
                    legal     = 1'b1;
                    lane_en   = 4'b1111;
                    lane_data = WriteData;
                end
            end
            2'b01: begin
                if (!DataAdr[0]) begin
                    legal     = 1'b1;
                    lane_en   = DataAdr[1] ? 4'b1100 : 4'b0011;
                    lane_data = {2{WriteData[15:0]}};
                end
            end
            2'b10: begin
                legal     = 1'b1;
                lane_en   = 4'b0001 << DataAdr[1:0];
                lane_data = {4{WriteData[7:0]}};
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Storage has no reset so its contents survive a mid-test reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[mem_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        ReadData = '0;
        if (in_range) begin
            ReadData = mem[mem_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MisalignErr <= 1'b0;
            WriteCount  <= '0;
        end else begin
            if (illegal) begin
                MisalignErr <= 1'b1;
            end
            if (accept && (WriteCount != '1)) begin
                WriteCount <= WriteCount + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any store into the window decides the verdict, whatever its width,
    // legality or range; the ignore address is the one exemption.
    always_comb begin
        state_d  = state_q;
        TestDone = 1'b0;
        TestPass = 1'b0;
        case (state_q)
            IDLE: begin
                if (store_req && win_hit) begin
                    if ((DataAdr == PASS_ADDR) && (WriteData == PASS_VALUE)) begin
                        state_d = PASS;
                    end else if (DataAdr == IGNORE_ADDR) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FAIL;
                    end
                end
            end
            PASS: begin
                TestDone = 1'b1;
                TestPass = 1'b1;
            end
            FAIL: begin
                TestDone = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder at default parameters.
//   A vector table covers store widths, alignment, range and the sticky
//   error flag; hand-written sequences cover read-during-write, the
//   mailbox verdicts and reset behaviour.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [1:0]  MemWidth;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        TestDone;
    logic        TestPass;
    logic        MisalignErr;
    logic [15:0] WriteCount;

    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;
    localparam logic [1:0] W_RSVD = 2'b11;

    typedef struct {
        logic        we;
        logic [1:0]  width;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [15:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int total = 0;
    int bad   = 0;

    data_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .MemWidth    (MemWidth),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .TestDone    (TestDone),
        .TestPass    (TestPass),
        .MisalignErr (MisalignErr),
        .WriteCount  (WriteCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        MemWrite  = v.we;
        MemWidth  = v.width;
        DataAdr   = v.adr;
        WriteData = v.wdata;
        sb.push_back(v);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("vec%0d ReadData", idx), ReadData, e.exp_rd);
        chk($sformatf("vec%0d WriteCount", idx), {16'h0, WriteCount}, {16'h0, e.exp_cnt});
        chk($sformatf("vec%0d MisalignErr", idx), {31'h0, MisalignErr}, {31'h0, e.exp_err});
    endtask

    // Drive one store for exactly one rising edge, then sample #1 after it.
    task automatic st(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite  = 1'b1;
        MemWidth  = w;
        DataAdr   = a;
        WriteData = d;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_verdict(input string nm, input logic done, input logic pass);
        chk({nm, " TestDone"}, {31'h0, TestDone}, {31'h0, done});
        chk({nm, " TestPass"}, {31'h0, TestPass}, {31'h0, pass});
    endtask

    initial begin
        reset     = 1'b0;
        MemWrite  = 1'b0;
        MemWidth  = W_WORD;
        DataAdr   = '0;
        WriteData = '0;

        // we, width, adr, wdata, expected ReadData at adr, WriteCount, MisalignErr
        vecs.push_back('{1'b1, W_WORD, 32'd8,   32'hDEADBEEF, 32'hDEADBEEF, 16'd1,  1'b0});
        vecs.push_back('{1'b1, W_WORD, 32'd4,   32'hCAFEF00D, 32'hCAFEF00D, 16'd2,  1'b0});
        vecs.push_back('{1'b1, W_BYTE, 32'd9,   32'hFFFFFFAA, 32'hDEADAAEF, 16'd3,  1'b0});
        vecs.push_back('{1'b1, W_HALF, 32'd10,  32'hABCD1234, 32'h1234AAEF, 16'd4,  1'b0});
        vecs.push_back('{1'b1, W_WORD, 32'd6,   32'h11111111, 32'hCAFEF00D, 16'd4,  1'b1});
        vecs.push_back('{1'b1, W_HALF, 32'd5,   32'h00002222, 32'hCAFEF00D, 16'd4,  1'b1});
        vecs.push_back('{1'b1, W_BYTE, 32'd7,   32'h00000055, 32'h55FEF00D, 16'd5,  1'b1});
        vecs.push_back('{1'b1, W_HALF, 32'd6,   32'h0000BEEF, 32'hBEEFF00D, 16'd6,  1'b1});
        vecs.push_back('{1'b1, W_RSVD, 32'd4,   32'h33333333, 32'hBEEFF00D, 16'd6,  1'b1});
        vecs.push_back('{1'b0, W_WORD, 32'd8,   32'h44444444, 32'h1234AAEF, 16'd6,  1'b1});
        vecs.push_back('{1'b1, W_WORD, 32'd256, 32'h66666666, 32'h00000000, 16'd6,  1'b1});
        vecs.push_back('{1'b1, W_WORD, 32'd252, 32'h0BADC0DE, 32'h0BADC0DE, 16'd7,  1'b1});
        vecs.push_back('{1'b1, W_WORD, 32'd12,  32'h11223344, 32'h11223344, 16'd8,  1'b1});
        vecs.push_back('{1'b1, W_BYTE, 32'd12,  32'h00000099, 32'h11223399, 16'd9,  1'b1});
        vecs.push_back('{1'b1, W_HALF, 32'd8,   32'h00005678, 32'h12345678, 16'd10, 1'b1});

        // Reset state
        @(negedge clk);
        chk_verdict("reset", 1'b0, 1'b0);
        chk("reset MisalignErr", {31'h0, MisalignErr}, 32'h0);
        chk("reset WriteCount", {16'h0, WriteCount}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) apply(vecs[i], i);
        chk("table TestDone", {31'h0, TestDone}, 32'h0);

        // Same-word store and read: old value before the edge, new after.
        @(negedge clk);
        MemWrite  = 1'b1;
        MemWidth  = W_WORD;
        DataAdr   = 32'd12;
        WriteData = 32'h55667788;
        #2;
        chk("rdw before edge", ReadData, 32'h11223399);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        chk("rdw after edge", ReadData, 32'h55667788);
        chk("rdw WriteCount", {16'h0, WriteCount}, 32'd11);

        // Mailbox: ignore address, then pass value.
        do_reset();
        chk("reset clears count", {16'h0, WriteCount}, 32'h0);
        chk("reset clears err", {31'h0, MisalignErr}, 32'h0);
        st(W_WORD, 32'd96, 32'd7);
        chk_verdict("ignore 96", 1'b0, 1'b0);
        st(W_WORD, 32'd100, 32'd25);
        chk_verdict("pass 100", 1'b1, 1'b1);

        // After PASS: further store, then reset mid-cycle.
        st(W_WORD, 32'd100, 32'd0);
        chk("post-pass store", ReadData, 32'h0);
        chk("post-pass count", {16'h0, WriteCount}, 32'd3);
        chk_verdict("post-pass terminal", 1'b1, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_verdict("async reset", 1'b0, 1'b0);
        chk("async reset count", {16'h0, WriteCount}, 32'h0);
        chk("async reset rd100", ReadData, 32'h0);
        MemWrite  = 1'b1;
        MemWidth  = W_WORD;
        DataAdr   = 32'd100;
        WriteData = 32'h000000FF;
        repeat (2) @(posedge clk);
        #1;
        chk("store in reset rd", ReadData, 32'h0);
        chk("store in reset count", {16'h0, WriteCount}, 32'h0);
        @(negedge clk);
        reset     = 1'b1;
        WriteData = 32'h00000099;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        chk("first edge after release rd", ReadData, 32'h0);
        chk("first edge after release count", {16'h0, WriteCount}, 32'h0);
        chk_verdict("first edge after release", 1'b0, 1'b0);
        @(posedge clk);
        st(W_WORD, 32'd100, 32'd25);
        chk("re-pass count", {16'h0, WriteCount}, 32'd1);
        chk_verdict("re-pass", 1'b1, 1'b1);

        // Mailbox: wrong value at pass address.
        do_reset();
        chk_verdict("cleared before fail24", 1'b0, 1'b0);
        st(W_WORD, 32'd100, 32'd24);
        chk_verdict("fail 24 at 100", 1'b1, 1'b0);
        st(W_WORD, 32'd100, 32'd25);
        chk_verdict("fail terminal", 1'b1, 1'b0);
        chk("fail terminal count", {16'h0, WriteCount}, 32'd2);

        // Mailbox: other address inside the window; byte store at an odd
        // offset still counts as a hit.
        do_reset();
        st(W_WORD, 32'd104, 32'd5);
        chk_verdict("fail 5 at 104", 1'b1, 1'b0);
        do_reset();
        st(W_BYTE, 32'd119, 32'd25);
        chk_verdict("fail byte at 119", 1'b1, 1'b0);
        do_reset();
        st(W_WORD, 32'd120, 32'd25);
        chk_verdict("window edge 120", 1'b0, 1'b0);
        st(W_HALF, 32'd91, 32'd25);
        chk_verdict("illegal half at 91", 1'b1, 1'b0);
        chk("illegal half err", {31'h0, MisalignErr}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit storage words.
REQ-002 Parameter PASS_ADDR, default 100, byte address of the test mailbox.
REQ-003 Parameter PASS_VALUE, default 25, mailbox value that signals success.
REQ-004 Parameter IGNORE_ADDR, default 96, byte address that is exempt from mailbox checking.
REQ-005 Parameters WIN_LO and WIN_HI, defaults 90 and 120, form the exclusive bounds of the mailbox window.
REQ-006 Port clk, input, 1 bit, single clock; all state updates on the rising edge.
REQ-007 Port reset, input, 1 bit, asynchronous active-low reset.
REQ-008 Port MemWrite, input, 1 bit, store request, sampled on the rising edge of clk.
REQ-009 Port MemWidth, input, 2 bits, store width: 00 = word, 01 = half, 10 = byte, 11 = reserved.
REQ-010 Port DataAdr, input, 32 bits, byte address from the core.
REQ-011 Port WriteData, input, 32 bits, store data, LSB-aligned.
REQ-012 Port ReadData, output, 32 bits, word at DataAdr.
REQ-013 Port TestDone, output, 1 bit, mailbox verdict reached.
REQ-014 Port TestPass, output, 1 bit, verdict is pass.
REQ-015 Port MisalignErr, output, 1 bit, sticky flag for a dropped illegal store.
REQ-016 Port WriteCount, output, 16 bits, count of accepted stores.

Function
REQ-017 Word index: DataAdr[31:2]; in range when the index is less than DEPTH_WORDS.
REQ-018 ReadData is a combinational read of the word at the index.
- An out-of-range index reads 0.
- Load width and sign extension are the core's job.
REQ-019 A store is accepted when MemWrite=1 at the rising edge, the index is in range, and the store is legal.
REQ-020 Legal store encodings, with WriteData LSB bits placed in the lanes shown:
- Word: DataAdr[1:0]=00, all 4 lanes written.
- Half: DataAdr[0]=0, 2 lanes written at DataAdr[1]*2.
- Byte: any offset, 1 lane written at DataAdr[1:0].
- All lanes outside the written ones are preserved.
REQ-021 An illegal store is dropped with no array write and no count increment, and sets MisalignErr the next cycle. Illegal means:
- a misaligned word or half store, or
- MemWidth=11.
REQ-022 An out-of-range legal store is dropped silently, with no flag and no count increment.
REQ-023 Simultaneous store and read of the same word: ReadData shows the old value until after the edge, then the new value.
REQ-024 WriteCount increments by 1 per accepted store and saturates at 0xFFFF.
REQ-025 The mailbox FSM has states IDLE, PASS, and FAIL; TestDone = (state != IDLE) and TestPass = (state == PASS).
REQ-026 In IDLE, a window hit is any MemWrite=1 edge with WIN_LO < DataAdr < WIN_HI, regardless of width, legality, or range.
REQ-027 Window-hit transitions out of IDLE:
- DataAdr == PASS_ADDR and WriteData == PASS_VALUE goes to PASS.
- DataAdr == IGNORE_ADDR stays in IDLE.
- Any other window hit goes to FAIL.
REQ-028 PASS and FAIL are terminal until reset; later stores still update the array and WriteCount.
REQ-029 The verdict is visible on TestDone/TestPass one cycle after the deciding edge, i.e. the cycle after the store.

Reset
REQ-030 Asserting reset=0 immediately forces the following, independent of clk:
- FSM to IDLE;
- TestDone=0, TestPass=0;
- MisalignErr=0;
- WriteCount=0.
REQ-031 Storage contents are not cleared by reset; ReadData stays combinational from the retained array during and after reset.
REQ-032 Stores presented while reset=0 are ignored.
REQ-033 Reset release is synchronized internally (two-flop) so the first accepted store occurs no earlier than the second rising edge after deassertion.
REQ-034 Reset mid-test clears the verdict; a new verdict can be reached after release.

Verification
REQ-035 Word store 0xDEADBEEF to address 8, then read address 8 -> ReadData=0xDEADBEEF, WriteCount=1.
REQ-036 Byte store 0xAA to address 9 over 0xDEADBEEF -> ReadData=0xDEADAAEF; half store 0x1234 to address 10 -> 0x1234AAEF.
REQ-037 Word store to address 6 -> array unchanged, MisalignErr=1, WriteCount unchanged.
REQ-038 Mailbox cases, one per run:
- Store 7 to 96, then 25 to 100 -> TestDone=1, TestPass=1 one cycle later.
- Store 24 to 100 -> TestDone=1, TestPass=0.
- Store 5 to 104 -> TestDone=1, TestPass=0.
REQ-039 After PASS, store 0 to 100, assert reset=0 mid-cycle, then release:
- before release: TestDone=0 immediately, WriteCount=0, address 100 reads 0;
- after release, store 25 to 100 -> PASS again.
REQ-040 Store to word index DEPTH_WORDS (address 256 at defaults) -> no write, no flag, WriteCount unchanged, ReadData=0.
